uart_byte_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_byte_tx_if.sv | 16 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_byte_tx.sv | 115 +++++++++++
 tb/tb_uart_byte_tx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types, line levels and baud-divisor helper
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam int   UART_DATA_BITS = 8;

  // Clocks per bit, rounded to nearest; shared with the receive side.
  function automatic int baud_set(input longint clk_freq, input longint baud_rate);
    return int'((clk_freq * 10 / baud_rate + 5) / 10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx_if.sv
`default_nettype none
// ============================================================================
// uart_byte_tx_if : byte valid/ready handshake into the UART transmitter
// Rev 1.0
// ============================================================================
interface uart_byte_tx_if;

  logic [7:0] data_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output data_byte, output tx_valid, input tx_ready);
  modport slave  (input data_byte, input tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : bit-period counter, ticks on the last cycle of each bit
// Rev 1.0
// ============================================================================
module uart_baud_tick #(
  parameter int BAUD_SET = 109
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_tick,
  output logic      o_pre_tick
);

  localparam logic [31:0] C_LAST = 32'(BAUD_SET - 1);
  localparam logic [31:0] C_PRE  = 32'(BAUD_SET - 2);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= 32'd0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == C_LAST) ? 32'd0 : r_cnt + 32'd1;
    end
  end

  // Pre-tick lets the parent register outputs that must be valid on the last cycle.
  assign o_tick     = i_enable && (r_cnt == C_LAST);
  assign o_pre_tick = i_enable && (r_cnt == C_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// uart_byte_tx : 8N1 UART byte transmitter with valid/ready input and irq
// Rev 1.0
// ============================================================================
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 921600
) (
  input  wire logic       clk_100M,
  input  wire logic       rst,
  uart_byte_tx_if.slave   bus,
  output logic            TX,
  output logic            irq
);

  localparam int BAUD_SET = baud_set(longint'(CLK_FREQ), longint'(BAUD_RATE));

  if (BAUD_SET < 2) begin : g_baud_check
    $error("uart_byte_tx: BAUD_SET must be at least 2");
  end

  uart_state_e r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_idx;
  logic        r_tx;
  logic        r_tx_ready;
  logic        r_irq;
  logic        w_tick;
  logic        w_pre_tick;
  logic        w_accept;
  logic        w_enable;

  assign w_accept = bus.tx_valid && r_tx_ready;
  assign w_enable = (r_state != IDLE);

  uart_baud_tick #(
    .BAUD_SET (BAUD_SET)
  ) u_baud_tick (
    .clk        (clk_100M),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_enable   (w_enable),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_idx      <= 3'd0;
      r_tx       <= UART_IDLE_LVL;
      r_tx_ready <= 1'b1;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= START;
            r_tx       <= UART_START_LVL;
            r_tx_ready <= 1'b0;
            r_shift    <= bus.data_byte;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_idx   <= 3'd0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == 3'(UART_DATA_BITS - 1)) begin
              r_state <= STOP;
              r_tx    <= UART_IDLE_LVL;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
        STOP: begin
          // irq and ready go high together for the final stop cycle so a
          // queued byte starts its start bit with no idle gap.
          if (w_pre_tick) begin
            r_irq      <= 1'b1;
            r_tx_ready <= 1'b1;
          end else if (w_tick) begin
            if (w_accept) begin
              r_state    <= START;
              r_tx       <= UART_START_LVL;
              r_tx_ready <= 1'b0;
              r_shift    <= bus.data_byte;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX           = r_tx;
  assign irq          = r_irq;
  assign bus.tx_ready = r_tx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_byte_tx : scoreboard bench, cycle-exact line monitor + loopback RX
// Rev 1.0
// ============================================================================
module tb_uart_byte_tx;

  localparam int BS_A    = 109;
  localparam int FRAME_A = 10 * BS_A;
  localparam int BS_B    = 868;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_a, irq_a, tx_b, irq_b;

  int n_cmp     = 0;
  int n_bad     = 0;
  int irq_cnt_a = 0;
  int rx_cnt_b  = 0;

  exp_t       q_a[$];
  logic [7:0] q_b[$];

  uart_byte_tx_if bus_a();
  uart_byte_tx_if bus_b();

  uart_byte_tx #(
    .CLK_FREQ  (100_000_000),
    .BAUD_RATE (921600)
  ) u_dut_a (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus_a),
    .TX       (tx_a),
    .irq      (irq_a)
  );

  uart_byte_tx #(
    .CLK_FREQ  (100_000_000),
    .BAUD_RATE (115200)
  ) u_dut_b (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus_b),
    .TX       (tx_b),
    .irq      (irq_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (irq_a === 1'b1) irq_cnt_a <= irq_cnt_a + 1;
  end

  // Cycle-exact check of every DUT A frame against the expected byte queue.
  initial begin : mon_a
    exp_t       e;
    int         idle, wbad, ibad, rbad, k;
    logic [7:0] got;
    logic       exp_tx;
    bit         aborted;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst || tx_a !== 1'b0) begin
        idle = rst ? 0 : idle + 1;
        continue;
      end
      if (q_a.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        e = '{8'h00, -1};
      end else begin
        e = q_a.pop_front();
      end
      if (e.gap >= 0) chk("frame_gap", idle, e.gap);
      wbad = 0; ibad = 0; rbad = 0; got = 8'h00; aborted = 0;
      for (int c = 0; c < FRAME_A; c++) begin
        if (c > 0) @(negedge clk);
        if (rst) begin
          aborted = 1;
          break;
        end
        k = c / BS_A;
        exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e.data[k-1];
        if (tx_a !== exp_tx) wbad++;
        if (irq_a !== (c == FRAME_A - 1)) ibad++;
        if (bus_a.tx_ready !== (c == FRAME_A - 1)) rbad++;
        if (k >= 1 && k <= 8 && (c % BS_A) == BS_A / 2) got[k-1] = tx_a;
      end
      idle = 0;
      if (!aborted) begin
        chk("frame_wave_bad_cycles", wbad, 0);
        chk("frame_irq_bad_cycles", ibad, 0);
        chk("frame_ready_bad_cycles", rbad, 0);
        chk("frame_data", int'(got), int'(e.data));
      end
    end
  end

  // Behavioural byte receiver on DUT B's line, mid-bit sampling.
  initial begin : rx_b
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst || tx_b !== 1'b0) continue;
      repeat (BS_B / 2) @(negedge clk);
      chk("rx_start", int'(tx_b), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BS_B) @(negedge clk);
        d[i] = tx_b;
      end
      repeat (BS_B) @(negedge clk);
      chk("rx_stop", int'(tx_b), 1);
      if (q_b.size() == 0) begin
        chk("rx_unexpected", 1, 0);
        e = 8'h00;
      end else begin
        e = q_b.pop_front();
      end
      chk("rx_data", int'(d), int'(e));
      rx_cnt_b++;
    end
  end

  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (bus_a.tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.tx_ready !== 1'b1) chk("ready_a_timeout", 0, 1);
  endtask

  task automatic wait_ready_b();
    int n = 0;
    @(negedge clk);
    while (bus_b.tx_ready !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    if (bus_b.tx_ready !== 1'b1) chk("ready_b_timeout", 0, 1);
  endtask

  task automatic send_a(input logic [7:0] b, input int gap);
    wait_ready_a();
    q_a.push_back('{b, gap});
    bus_a.data_byte = b;
    bus_a.tx_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    chk("handshake_latency", int'(tx_a), 0);
    chk("ready_drop", int'(bus_a.tx_ready), 0);
  endtask

  // Second byte is presented during the first frame and must follow with no gap.
  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    wait_ready_a();
    q_a.push_back('{b0, -1});
    q_a.push_back('{b1, 0});
    bus_a.data_byte = b0;
    bus_a.tx_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.data_byte = b1;
    chk("pair_latency", int'(tx_a), 0);
    wait_ready_a();
    @(posedge clk);
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    chk("pair_second_start", int'(tx_a), 0);
  endtask

  initial begin : stim
    int base, bad, n;
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'h7E; lb[2] = 8'hFF; lb[3] = 8'h5A;
    bus_a.tx_valid = 1'b0; bus_a.data_byte = 8'h00;
    bus_b.tx_valid = 1'b0; bus_b.data_byte = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", int'(tx_a), 1);
    chk("rst_ready", int'(bus_a.tx_ready), 1);
    chk("rst_irq", int'(irq_a), 0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || bus_a.tx_ready !== 1'b1 || irq_a !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);

    base = irq_cnt_a;
    send_a(8'hA5, -1);
    wait_ready_a();
    repeat (3) @(negedge clk);
    chk("irq_count_a5", irq_cnt_a - base, 1);

    base = irq_cnt_a;
    send_pair(8'h00, 8'hFF);
    wait_ready_a();
    repeat (3) @(negedge clk);
    chk("irq_count_b2b", irq_cnt_a - base, 2);

    base = irq_cnt_a;
    send_pair(8'h3C, 8'hFF);
    wait_ready_a();
    repeat (3) @(negedge clk);
    chk("irq_count_midchange", irq_cnt_a - base, 2);

    // Reset lands inside data bit 3 (cycles 436..544 of the frame).
    send_a(8'h55, -1);
    repeat (490) @(negedge clk);
    base = irq_cnt_a;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", int'(tx_a), 1);
    chk("abort_ready", int'(bus_a.tx_ready), 1);
    chk("abort_irq_level", int'(irq_a), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_irq_count", irq_cnt_a - base, 0);

    base = irq_cnt_a;
    send_a(8'h81, -1);
    wait_ready_a();
    repeat (3) @(negedge clk);
    chk("irq_count_81", irq_cnt_a - base, 1);

    for (int i = 0; i < 4; i++) begin
      wait_ready_b();
      q_b.push_back(lb[i]);
      bus_b.data_byte = lb[i];
      bus_b.tx_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_b.tx_valid = 1'b0;
    end
    n = 0;
    while (rx_cnt_b < 4 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_completions", rx_cnt_b, 4);
    chk("q_a_leftover", q_a.size(), 0);
    chk("q_b_leftover", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
